// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, forwarding selects,
// register-index width and the control-field bubble encoding.
package id_ex_stage_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Control fields that a bubble must clear; data fields are simply held.
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 rs1_use;
    logic                 rs2_use;
    logic [REG_IDX_W-1:0] waddr;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  function automatic logic reads_reg(input logic use_en,
                                     input logic [REG_IDX_W-1:0] idx,
                                     input logic [REG_IDX_W-1:0] rd);
    return use_en && (idx == rd);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and per-cycle priority
// (MemStall > branch flush > load-use bubble > normal advance).
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                 valid_ID,
  input  logic [REG_IDX_W-1:0] raddr1_ID,
  input  logic [REG_IDX_W-1:0] raddr2_ID,
  input  logic                 RS1Use_ID,
  input  logic                 RS2Use_ID,
  input  logic                 MemWrite_ID,
  input  logic                 valid_EX,
  input  logic                 MemRead_EX,
  input  logic                 RegWrite_EX,
  input  logic [REG_IDX_W-1:0] waddr_EX,
  input  logic [REG_IDX_W-1:0] waddr_MEM,
  input  logic                 RegWrite_MEM,
  input  logic                 MemRead_MEM,
  input  logic                 BranchTaken_EX,
  input  logic                 MemStall,
  output logic                 load_en,
  output logic                 bubble_sel,
  output logic                 Stall_IF,
  output logic                 Stall_ID,
  output logic                 Flush_ID
);

  logic use_ex, use_mem, hz_ex, hz_mem, hazard;

  always_comb begin
    // A store's rs2 is only store data, which can still be forwarded from MEM.
    use_ex  = reads_reg(RS1Use_ID, raddr1_ID, waddr_EX) |
              reads_reg(RS2Use_ID & ~MemWrite_ID, raddr2_ID, waddr_EX);
    use_mem = reads_reg(RS1Use_ID, raddr1_ID, waddr_MEM) |
              reads_reg(RS2Use_ID & ~MemWrite_ID, raddr2_ID, waddr_MEM);
    hz_ex   = valid_EX & MemRead_EX & RegWrite_EX & (waddr_EX != '0) & use_ex;
    hz_mem  = MemRead_MEM & RegWrite_MEM & (waddr_MEM != '0) & use_mem;
    hazard  = valid_ID & (hz_ex | hz_mem);

    load_en    = 1'b1;
    bubble_sel = 1'b0;
    Stall_IF   = 1'b0;
    Stall_ID   = 1'b0;
    Flush_ID   = 1'b0;

    if (MemStall) begin
      load_en  = 1'b0;
      Stall_IF = 1'b1;
      Stall_ID = 1'b1;
    end else if (BranchTaken_EX) begin
      bubble_sel = 1'b1;
      Flush_ID   = 1'b1;
    end else if (hazard) begin
      bubble_sel = 1'b1;
      Stall_IF   = 1'b1;
      Stall_ID   = 1'b1;
    end else begin
      bubble_sel = ~valid_ID;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// memory back-pressure. Define HAZARD_PERF_EN to add stall/flush counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_ID,
  input  logic [REG_IDX_W-1:0] raddr1_ID,
  input  logic [REG_IDX_W-1:0] raddr2_ID,
  input  logic                 RS1Use_ID,
  input  logic                 RS2Use_ID,
  input  logic [REG_IDX_W-1:0] waddr_ID,
  input  logic                 RegWrite_ID,
  input  logic                 MemRead_ID,
  input  logic                 MemWrite_ID,
  input  logic [ALUOP_W-1:0]   ALUCtrl_ID,
  input  logic [XLEN-1:0]      rdata1_ID,
  input  logic [XLEN-1:0]      rdata2_ID,
  input  logic [XLEN-1:0]      imm_ID,
  input  logic [XLEN-1:0]      pc_ID,
  input  logic [REG_IDX_W-1:0] waddr_MEM,
  input  logic                 RegWrite_MEM,
  input  logic                 MemRead_MEM,
  input  logic                 BranchTaken_EX,
  input  logic                 MemStall,
  output logic                 valid_EX,
  output logic [REG_IDX_W-1:0] raddr1_EX,
  output logic [REG_IDX_W-1:0] raddr2_EX,
  output logic                 RS1Use_EX,
  output logic                 RS2Use_EX,
  output logic [REG_IDX_W-1:0] waddr_EX,
  output logic                 RegWrite_EX,
  output logic                 MemRead_EX,
  output logic                 MemWrite_EX,
  output logic [ALUOP_W-1:0]   ALUCtrl_EX,
  output logic [XLEN-1:0]      rdata1_EX,
  output logic [XLEN-1:0]      rdata2_EX,
  output logic [XLEN-1:0]      imm_EX,
  output logic [XLEN-1:0]      pc_EX,
  output logic                 Stall_IF,
  output logic                 Stall_ID,
  output logic                 Flush_ID
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam int DATA_W = 2 * REG_IDX_W + ALUOP_W + 4 * XLEN;

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d, data_id;
  logic              load_en, bubble_sel;

  hazard_detect u_hazard_detect (
    .valid_ID       (valid_ID),
    .raddr1_ID      (raddr1_ID),
    .raddr2_ID      (raddr2_ID),
    .RS1Use_ID      (RS1Use_ID),
    .RS2Use_ID      (RS2Use_ID),
    .MemWrite_ID    (MemWrite_ID),
    .valid_EX       (ctrl_q.valid),
    .MemRead_EX     (ctrl_q.mem_read),
    .RegWrite_EX    (ctrl_q.reg_write),
    .waddr_EX       (ctrl_q.waddr),
    .waddr_MEM      (waddr_MEM),
    .RegWrite_MEM   (RegWrite_MEM),
    .MemRead_MEM    (MemRead_MEM),
    .BranchTaken_EX (BranchTaken_EX),
    .MemStall       (MemStall),
    .load_en        (load_en),
    .bubble_sel     (bubble_sel),
    .Stall_IF       (Stall_IF),
    .Stall_ID       (Stall_ID),
    .Flush_ID       (Flush_ID)
  );

  assign data_id = {raddr1_ID, raddr2_ID, ALUCtrl_ID, rdata1_ID, rdata2_ID, imm_ID, pc_ID};

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load_en) begin
      if (bubble_sel) begin
        ctrl_d = BUBBLE_CTRL;
      end else begin
        ctrl_d = '{valid: 1'b1, reg_write: RegWrite_ID, mem_read: MemRead_ID,
                   mem_write: MemWrite_ID, rs1_use: RS1Use_ID, rs2_use: RS2Use_ID,
                   waddr: waddr_ID};
        data_d = data_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= BUBBLE_CTRL;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign valid_EX    = ctrl_q.valid;
  assign RegWrite_EX = ctrl_q.reg_write;
  assign MemRead_EX  = ctrl_q.mem_read;
  assign MemWrite_EX = ctrl_q.mem_write;
  assign RS1Use_EX   = ctrl_q.rs1_use;
  assign RS2Use_EX   = ctrl_q.rs2_use;
  assign waddr_EX    = ctrl_q.waddr;
  assign {raddr1_EX, raddr2_EX, ALUCtrl_EX, rdata1_EX, rdata2_EX, imm_EX, pc_EX} = data_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // A stall without MemStall can only be a load-use bubble.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, Stall_IF & ~MemStall};
    flush_cnt_d = flush_cnt_q + {31'd0, Flush_ID};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
